// File: rtl/ascii_char_tx.sv
// Buffers host-written ASCII bytes in a circular FIFO and on start streams them out, followed by a terminator.
// Latency: start sampled at edge N gives the first character with out_valid=1 from cycle N+1; with out_ready held high, one character per cycle.
// Backpressure: out_ready=0 freezes out/out_valid and the FSM; a write while full is dropped and sets the sticky overflow flag.
module ascii_char_tx #(
    parameter int          DEPTH     = 8,
    parameter logic [7:0]  TERM_CHAR = 8'h20,
    parameter logic [7:0]  IDLE_CHAR = 8'h00
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    output logic        full,
    output logic        overflow,
    input  logic        start,
    output logic        busy,
    output logic [7:0]  out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        done,
    output logic [7:0]  sent_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE, SEND, TERM, DONE} state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [AW:0]     count;
    logic            wr_acc;
    logic            pop;
    logic            start_acc;

    // A write while full is dropped even if a pop happens in the same cycle.
    assign full      = (count == DEPTH_C);
    assign wr_acc    = wr_en && !full;
    assign pop       = (state == SEND) && out_ready;
    assign start_acc = (state == IDLE) && start && (count != '0);

    assign out_valid = (state == SEND) || (state == TERM);
    assign busy      = (state == SEND) || (state == TERM);
    assign done      = (state == DONE);

    // Output character decoded from registered state and FIFO head only.
    always_comb begin
        out = IDLE_CHAR;
        case (state)
            SEND:    out = mem[rptr];
            TERM:    out = TERM_CHAR;
            default: out = IDLE_CHAR;
        endcase
    end

    // Character storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr] <= wr_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr_acc, pop})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: count <= count;
            endcase
        end
    end

    // Transmit FSM with the per-transaction character count and sticky overflow.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= IDLE;
            sent_cnt <= 8'd0;
            overflow <= 1'b0;
        end else begin
            if (start_acc) begin
                overflow <= 1'b0;
            end
            // A drop in the same cycle as an accepted start still leaves overflow set.
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start_acc) begin
                        state    <= SEND;
                        sent_cnt <= 8'd0;
                    end
                end
                SEND: begin
                    if (pop) begin
                        if (sent_cnt != 8'hFF) begin
                            sent_cnt <= sent_cnt + 8'd1;
                        end
                        // Leave for the terminator only when this pop drains the FIFO.
                        if (count == ONE_C && !wr_acc) begin
                            state <= TERM;
                        end
                    end
                end
                TERM: begin
                    if (out_ready) begin
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ascii_char_tx.md
# ascii_char_tx

Character-stream transmitter: buffers ASCII bytes written by a host into a small FIFO and, on a start pulse, emits them one per accepted handshake on an 8-bit output, followed by a terminator character. It is the producing end of the per-clock character interface consumed by our identifier-recognition FSM, and sources token streams for it in system-level benches and on-chip self-test.

## Interface
- DEPTH, 8, FIFO depth in characters; power of two, 2..16
- TERM_CHAR, 8'h20, terminator emitted after the last buffered character
- IDLE_CHAR, 8'h00, value driven on `out` when nothing is being sent
- clk  input  1  sole clock, rising edge
- clr  input  1  reset, asynchronous, active-low (0 = reset)
- wr_en  input  1  write strobe for wr_data
- wr_data  input  8  ASCII character to buffer
- full  output  1  FIFO holds DEPTH characters
- overflow  output  1  sticky: a write was dropped because FIFO was full
- start  input  1  one-cycle request to begin transmission
- busy  output  1  high in SEND and TERM
- out  output  8  current character
- out_valid  output  1  `out` carries a character to be consumed
- out_ready  input  1  consumer accepts `out` this cycle
- done  output  1  one-cycle pulse after terminator accepted
- sent_cnt  output  8  data characters accepted in current/last transaction

## Operation
- FIFO: circular buffer, read/write pointers of log2(DEPTH) bits plus count of log2(DEPTH)+1 bits; pointers wrap at DEPTH.
- Write accepted when wr_en=1 and full=0, in any state. wr_en=1 with full=1 drops the byte and sets overflow; overflow clears only on reset or on an accepted start.
- Pop occurs when state=SEND and out_valid=1 and out_ready=1. Simultaneous write and pop: count unchanged, both pointers advance; allowed also when full.
- States: IDLE, SEND, TERM, DONE.
- IDLE: out=IDLE_CHAR, out_valid=0. start=1 with count>0 -> SEND, sent_cnt cleared to 0, overflow cleared. start=1 with count=0 -> ignored, stay IDLE.
- SEND: out=FIFO head, out_valid=1. On pop, sent_cnt increments (saturates at 255). If pop leaves FIFO empty (count=1, no same-cycle write) -> TERM; otherwise stay SEND.
- TERM: out=TERM_CHAR, out_valid=1. out_ready=1 -> DONE. sent_cnt not incremented for the terminator.
- DONE: out=IDLE_CHAR, out_valid=0, done=1 for this cycle only -> IDLE.
- start outside IDLE is ignored.
- out and out_valid are decoded from registered state and FIFO head only; no combinational path from out_ready or start to out/out_valid.

## Timing
- Reset (clr=0, any time incl. mid-transmission): state IDLE, FIFO emptied, out=IDLE_CHAR, out_valid=0, full=0, overflow=0, busy=0, done=0, sent_cnt=0. Effect immediate, not clock-gated.
- start sampled at edge N -> out_valid=1 with first character from cycle N+1.
- With out_ready held 1: one character per cycle, terminator in the cycle after the last data character, done in the cycle after that, IDLE the next. K characters: K+2 cycles from first out_valid to done.
- out_ready=0: out and out_valid hold their values unchanged; no pop, no state change.
- full reflects count after the edge; a write in the same cycle as full=1 is dropped even if a pop also occurs.
- start may be asserted in the same cycle as the first wr_en only if count>0 already; a byte written at edge N is visible to start at edge N+1.

## Test plan
- Write 'a','b','1' (0x61,0x62,0x31), pulse start, out_ready=1 -> out = 0x61,0x62,0x31,0x20 on four consecutive cycles with out_valid=1, then done=1 one cycle, sent_cnt=3, busy=0.
- Same stream with out_ready=0 for 3 cycles while out=0x62 -> out stays 0x62, out_valid stays 1, sent_cnt stays 1; resumes with 0x31 after ready returns.
- Write 9 bytes 0x30..0x38 into empty FIFO -> full=1 after 8th, overflow=1, 0x38 dropped; start transmits 0x30..0x37 then 0x20, sent_cnt=8; overflow cleared by the start.
- start with FIFO empty -> out_valid stays 0, busy stays 0, done never pulses.
- Load '2', start, write '6' in the cycle '2' is accepted -> no terminator yet; out = 0x32,0x36,0x20; sent_cnt=2.
- Load "26*7", start, drive clr=0 while out=0x36 -> out=0x00, out_valid=0, busy=0, sent_cnt=0 immediately; after release FIFO is empty and start is ignored.
